// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two-requester round-robin scheduler sharing one branch comparator.
// Requests (cmpop, a, b, tag) are accepted over valid/ready, registered into a
// single issue stage that drives the comparator, and the comparator result is
// captured into a per-requester single-entry response buffer.
// Ports:
//   clk_i, rst_ni                  - clock, async active-low reset
//   reqN_valid_i/ready_o           - request handshake for requester N
//   reqN_cmpop_i, reqN_a_i/b_i     - branch funct3 encoding and operands
//   reqN_tag_i                     - opaque tag echoed in the response
//   respN_valid_o/ready_i          - response handshake for requester N
//   respN_br_en_o/illegal_o/tag_o  - compare result, illegal flag, tag
//   cmp_cmpop_o, cmp_a_o, cmp_b_o  - drive the shared comparator
//   cmp_br_en_i                    - comparator result
module cmp_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_cmpop_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             resp0_valid_o,
  input  logic             resp0_ready_i,
  output logic             resp0_br_en_o,
  output logic             resp0_illegal_o,
  output logic [TAG_W-1:0] resp0_tag_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_cmpop_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             resp1_valid_o,
  input  logic             resp1_ready_i,
  output logic             resp1_br_en_o,
  output logic             resp1_illegal_o,
  output logic [TAG_W-1:0] resp1_tag_o,
  output logic [2:0]       cmp_cmpop_o,
  output logic [31:0]      cmp_a_o,
  output logic [31:0]      cmp_b_o,
  input  logic             cmp_br_en_i
);

  logic [1:0] out_q, out_d;
  logic       ptr_q, ptr_d;
  logic [1:0] req_valid, req_ready, eligible, accept, resp_hs;

  logic             issue_valid_q, issue_valid_d;
  logic             issue_owner_q, issue_owner_d;
  logic [2:0]       issue_cmpop_q, issue_cmpop_d;
  logic [31:0]      issue_a_q, issue_a_d;
  logic [31:0]      issue_b_q, issue_b_d;
  logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
  logic             issue_illegal;

  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [1:0]       resp_br_en_q, resp_br_en_d;
  logic [1:0]       resp_illegal_q, resp_illegal_d;
  logic [TAG_W-1:0] resp_tag_q [2];
  logic [TAG_W-1:0] resp_tag_d [2];

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign resp_hs   = resp_valid_q & {resp1_ready_i, resp0_ready_i};
  assign eligible  = req_valid & ~out_q;

  // Ready is independent of the requester's own valid; at most one grant per cycle.
  assign req_ready[0] = ~out_q[0] & (~ptr_q | ~eligible[1]);
  assign req_ready[1] = ~out_q[1] & (ptr_q | ~eligible[0]);
  assign accept       = req_valid & req_ready;

  assign req0_ready_o = req_ready[0];
  assign req1_ready_o = req_ready[1];

  // 010 and 011 are the only non-branch funct3 encodings.
  assign issue_illegal = (issue_cmpop_q[2:1] == 2'b01);

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) begin
        out_d[i] = 1'b1;
      end else if (resp_hs[i]) begin
        out_d[i] = 1'b0;
      end
    end
    ptr_d = ptr_q;
    if (accept[0]) begin
      ptr_d = 1'b1;
    end else if (accept[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_comb begin
    issue_valid_d = |accept;
    issue_owner_d = issue_owner_q;
    issue_cmpop_d = issue_cmpop_q;
    issue_a_d     = issue_a_q;
    issue_b_d     = issue_b_q;
    issue_tag_d   = issue_tag_q;
    if (accept[0]) begin
      issue_owner_d = 1'b0;
      issue_cmpop_d = req0_cmpop_i;
      issue_a_d     = req0_a_i;
      issue_b_d     = req0_b_i;
      issue_tag_d   = req0_tag_i;
    end else if (accept[1]) begin
      issue_owner_d = 1'b1;
      issue_cmpop_d = req1_cmpop_i;
      issue_a_d     = req1_a_i;
      issue_b_d     = req1_b_i;
      issue_tag_d   = req1_tag_i;
    end
  end

  always_comb begin
    cmp_cmpop_o = 3'b000;
    cmp_a_o     = '0;
    cmp_b_o     = '0;
    if (issue_valid_q && !issue_illegal) begin
      cmp_cmpop_o = issue_cmpop_q;
      cmp_a_o     = issue_a_q;
      cmp_b_o     = issue_b_q;
    end
  end

  // The owner's buffer is always empty when its operation issues, so no stall.
  always_comb begin
    resp_valid_d   = resp_valid_q;
    resp_br_en_d   = resp_br_en_q;
    resp_illegal_d = resp_illegal_q;
    resp_tag_d     = resp_tag_q;
    for (int i = 0; i < 2; i++) begin
      if (issue_valid_q && (issue_owner_q == i[0])) begin
        resp_valid_d[i]   = 1'b1;
        resp_br_en_d[i]   = cmp_br_en_i & ~issue_illegal;
        resp_illegal_d[i] = issue_illegal;
        resp_tag_d[i]     = issue_tag_q;
      end else if (resp_hs[i]) begin
        resp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q          <= '0;
      ptr_q          <= 1'b0;
      issue_valid_q  <= 1'b0;
      issue_owner_q  <= 1'b0;
      issue_cmpop_q  <= '0;
      issue_a_q      <= '0;
      issue_b_q      <= '0;
      issue_tag_q    <= '0;
      resp_valid_q   <= '0;
      resp_br_en_q   <= '0;
      resp_illegal_q <= '0;
      resp_tag_q[0]  <= '0;
      resp_tag_q[1]  <= '0;
    end else begin
      out_q          <= out_d;
      ptr_q          <= ptr_d;
      issue_valid_q  <= issue_valid_d;
      issue_owner_q  <= issue_owner_d;
      issue_cmpop_q  <= issue_cmpop_d;
      issue_a_q      <= issue_a_d;
      issue_b_q      <= issue_b_d;
      issue_tag_q    <= issue_tag_d;
      resp_valid_q   <= resp_valid_d;
      resp_br_en_q   <= resp_br_en_d;
      resp_illegal_q <= resp_illegal_d;
      resp_tag_q[0]  <= resp_tag_d[0];
      resp_tag_q[1]  <= resp_tag_d[1];
    end
  end

  assign resp0_valid_o   = resp_valid_q[0];
  assign resp0_br_en_o   = resp_br_en_q[0];
  assign resp0_illegal_o = resp_illegal_q[0];
  assign resp0_tag_o     = resp_tag_q[0];
  assign resp1_valid_o   = resp_valid_q[1];
  assign resp1_br_en_o   = resp_br_en_q[1];
  assign resp1_illegal_o = resp_illegal_q[1];
  assign resp1_tag_o     = resp_tag_q[1];

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: requests push expected responses into
// per-requester queues; a monitor pops and compares on each response handshake.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_cmpop = '0, req1_cmpop = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic        resp0_br_en, resp1_br_en, resp0_illegal, resp1_illegal;
  logic [3:0]  resp0_tag, resp1_tag;
  logic [2:0]  cmp_cmpop;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_br_en;

  int checks = 0;
  int errors = 0;
  int n_resp1 = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int grants[$];
  logic [1:0] model_out = '0;

  always #5 clk = ~clk;

  cmp_arbiter #(.TAG_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_cmpop_i(req0_cmpop),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_tag_i(req0_tag),
    .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready), .resp0_br_en_o(resp0_br_en),
    .resp0_illegal_o(resp0_illegal), .resp0_tag_o(resp0_tag),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_cmpop_i(req1_cmpop),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_tag_i(req1_tag),
    .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready), .resp1_br_en_o(resp1_br_en),
    .resp1_illegal_o(resp1_illegal), .resp1_tag_o(resp1_tag),
    .cmp_cmpop_o(cmp_cmpop), .cmp_a_o(cmp_a), .cmp_b_o(cmp_b), .cmp_br_en_i(cmp_br_en)
  );

  // Behavioural stand-in for the shared CMP unit.
  always_comb begin
    cmp_br_en = 1'b0;
    case (cmp_cmpop)
      3'b000:  cmp_br_en = (cmp_a == cmp_b);
      3'b001:  cmp_br_en = (cmp_a != cmp_b);
      3'b100:  cmp_br_en = ($signed(cmp_a) < $signed(cmp_b));
      3'b101:  cmp_br_en = ($signed(cmp_a) >= $signed(cmp_b));
      3'b110:  cmp_br_en = (cmp_a < cmp_b);
      3'b111:  cmp_br_en = (cmp_a >= cmp_b);
      default: cmp_br_en = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // In-flight requests are discarded by reset.
  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
  end

  // Monitor: response scoreboard, grant log, ready-while-outstanding check.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_out <= '0;
    end else begin
      if (resp0_valid && resp0_ready) begin
        if (q0.size() == 0) chk("resp0_unexpected", 1, 0);
        else begin
          logic [5:0] e;
          e = q0.pop_front();
          chk("resp0_br_en", resp0_br_en, e[5]);
          chk("resp0_illegal", resp0_illegal, e[4]);
          chk("resp0_tag", resp0_tag, e[3:0]);
        end
      end
      if (resp1_valid && resp1_ready) begin
        n_resp1++;
        if (q1.size() == 0) chk("resp1_unexpected", 1, 0);
        else begin
          logic [5:0] e;
          e = q1.pop_front();
          chk("resp1_br_en", resp1_br_en, e[5]);
          chk("resp1_illegal", resp1_illegal, e[4]);
          chk("resp1_tag", resp1_tag, e[3:0]);
        end
      end
      if (model_out[0]) chk("req0_ready_while_outstanding", req0_ready, 0);
      if (model_out[1]) chk("req1_ready_while_outstanding", req1_ready, 0);
      if (req0_valid && req0_ready) grants.push_back(0);
      if (req1_valid && req1_ready) grants.push_back(1);
      if (req0_valid && req0_ready) model_out[0] <= 1'b1;
      else if (resp0_valid && resp0_ready) model_out[0] <= 1'b0;
      if (req1_valid && req1_ready) model_out[1] <= 1'b1;
      else if (resp1_valid && resp1_ready) model_out[1] <= 1'b0;
    end
  end

  // Present one request, wait (bounded) for acceptance, record expected response.
  task automatic send(input int r, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag,
                      input logic eb, input logic ei);
    int n = 0;
    bit ok = 0;
    if (r == 0) begin
      req0_cmpop = op; req0_a = a; req0_b = b; req0_tag = tag; req0_valid = 1'b1;
    end else begin
      req1_cmpop = op; req1_a = a; req1_b = b; req1_tag = tag; req1_valid = 1'b1;
    end
    while (!ok && n < 100) begin
      @(negedge clk);
      if (rst_n && ((r == 0) ? req0_ready : req1_ready)) ok = 1;
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else if (r == 0) q0.push_back({eb, ei, tag});
    else q1.push_back({eb, ei, tag});
    @(posedge clk);
    #1;
    if (r == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 1);
    chk("rst_req1_ready", req1_ready, 1);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_resp0_tag", resp0_tag, 0);
    chk("rst_cmp_cmpop", cmp_cmpop, 0);
    chk("rst_cmp_a", cmp_a, 0);
    @(posedge clk);
    #1;

    // Single request: bltu 1 < 0xFFFFFFFF unsigned
    send(0, 3'b110, 32'h1, 32'hFFFF_FFFF, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_cmp_cmpop", cmp_cmpop, 3'b110);
    chk("t1_cmp_a", cmp_a, 32'h1);
    chk("t1_cmp_b", cmp_b, 32'hFFFF_FFFF);
    chk("t1_ready_c1", req0_ready, 0);
    chk("t1_resp_valid_c1", resp0_valid, 0);
    @(negedge clk);
    chk("t1_resp_valid_c2", resp0_valid, 1);
    chk("t1_ready_c2", req0_ready, 0);
    @(posedge clk);
    #1;

    // Signed vs unsigned on requester 1
    send(1, 3'b100, 32'hFFFF_FFFF, 32'h1, 4'd4, 1'b1, 1'b0);
    send(1, 3'b111, 32'hFFFF_FFFF, 32'h1, 4'd5, 1'b1, 1'b0);
    send(1, 3'b101, 32'hFFFF_FFFF, 32'h1, 4'd6, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Contention from reset
    rst_n = 1'b0;
    grants.delete();
    fork
      begin repeat (2) @(posedge clk); #1 rst_n = 1'b1; end
      begin
        send(0, 3'b000, 32'd5, 32'd5, 4'd1, 1'b1, 1'b0);
        send(0, 3'b001, 32'd5, 32'd5, 4'd2, 1'b0, 1'b0);
        send(0, 3'b100, 32'h8000_0000, 32'd0, 4'd3, 1'b1, 1'b0);
        send(0, 3'b110, 32'h8000_0000, 32'd0, 4'd4, 1'b0, 1'b0);
      end
      begin
        send(1, 3'b101, 32'd3, 32'd3, 4'd9, 1'b1, 1'b0);
        send(1, 3'b111, 32'd2, 32'd3, 4'd10, 1'b0, 1'b0);
        send(1, 3'b100, 32'd3, 32'd2, 4'd11, 1'b0, 1'b0);
        send(1, 3'b111, 32'hFFFF_FFFF, 32'd0, 4'd12, 1'b1, 1'b0);
      end
    join
    chk("grant_count", grants.size(), 8);
    for (int k = 0; k < grants.size() && k < 8; k++) chk("grant_order", grants[k], k % 2);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure on requester 0 while requester 1 keeps working
    resp0_ready = 1'b0;
    send(0, 3'b000, 32'd5, 32'd5, 4'd6, 1'b1, 1'b0);
    begin
      int base;
      base = n_resp1;
      fork
        begin
          send(1, 3'b001, 32'd1, 32'd2, 4'd1, 1'b1, 1'b0);
          send(1, 3'b110, 32'd2, 32'd1, 4'd2, 1'b0, 1'b0);
          send(1, 3'b111, 32'd0, 32'd0, 4'd3, 1'b1, 1'b0);
        end
        begin
          @(negedge clk);
          repeat (5) begin
            @(negedge clk);
            chk("bp_resp0_valid", resp0_valid, 1);
            chk("bp_resp0_br_en", resp0_br_en, 1);
            chk("bp_resp0_tag", resp0_tag, 6);
            chk("bp_req0_ready", req0_ready, 0);
          end
          @(posedge clk);
          #1 resp0_ready = 1'b1;
          @(negedge clk);
          chk("bp_ready_hs_cycle", req0_ready, 0);
          @(negedge clk);
          chk("bp_ready_after_hs", req0_ready, 1);
        end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("bp_resp1_count", n_resp1 - base, 3);
    end

    // Illegal cmpop 010: comparator inputs zeroed, response flags illegal
    send(0, 3'b010, 32'd7, 32'd7, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk("ill_cmp_cmpop", cmp_cmpop, 0);
    chk("ill_cmp_a", cmp_a, 0);
    chk("ill_cmp_b", cmp_b, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the issue cycle discards the request
    send(0, 3'b000, 32'd9, 32'd9, 4'd5, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmp_a", cmp_a, 0);
    chk("mid_rst_cmp_cmpop", cmp_cmpop, 0);
    chk("mid_rst_resp0_valid", resp0_valid, 0);
    chk("mid_rst_req0_ready", req0_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_resp0_valid", resp0_valid, 0);
    end

    begin
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
